// File: rtl/shadow_reg_bank.sv
// Purpose: N-channel register bank with working and shadow copies; a staged
//   commit copies a masked set of channels into the shadow copy.
// Latency: reads are registered (1 cycle); a commit takes CHANNELS cycles.
// Backpressure: wr_ready drops for the whole commit, so writes stall until the
//   done cycle.
//
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   wr_valid/wr_ready/wr_chan/wr_data - write request into the working copy
//   commit/commit_mask - start a commit of the masked channels
//   busy/done    - commit in progress / one-cycle end-of-commit pulse
//   rd_chan/rd_shadow/rd_data - registered read of working or shadow copy
//   err          - sticky flag: out-of-range write attempted
module shadow_reg_bank #(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned INVERT   = 0,
  localparam int unsigned CW       = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CW-1:0]       wr_chan,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                commit,
  input  logic [CHANNELS-1:0] commit_mask,
  output logic                busy,
  output logic                done,
  input  logic [CW-1:0]       rd_chan,
  input  logic                rd_shadow,
  output logic [WIDTH-1:0]    rd_data,
  output logic                err
);

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  // Channel-count constants carried at CW+1 bits so that channel indices in
  // the unused upper range of a non-power-of-two bank compare correctly.
  localparam logic [CW:0] NUM_CH  = (CW+1)'(CHANNELS);
  localparam logic [CW:0] LAST_CH = (CW+1)'(CHANNELS - 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [CHANNELS-1:0]   mask_q, mask_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;
  logic [WIDTH-1:0]      working_q [CHANNELS];
  logic [WIDTH-1:0]      working_d [CHANNELS];
  logic [WIDTH-1:0]      shadow_q  [CHANNELS];
  logic [WIDTH-1:0]      shadow_d  [CHANNELS];

  logic                  wr_fire;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic [WIDTH-1:0]      rd_sel;

  assign wr_ready = (state_q == IDLE);
  assign busy     = (state_q == COMMIT);
  assign done     = done_q;
  assign err      = err_q;
  assign rd_data  = rd_data_q;

  // Next-state, storage update and commit sequencing.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mask_d      = mask_q;
    done_d      = 1'b0;
    err_d       = err_q;
    working_d   = working_q;
    shadow_d    = shadow_q;
    wr_fire     = wr_valid && wr_ready;
    wr_in_range = ({1'b0, wr_chan} < NUM_CH);

    case (state_q)
      IDLE: begin
        // The write lands this edge; copies start next edge, so a commit
        // issued alongside a write sees the new value.
        if (wr_fire) begin
          if (wr_in_range) begin
            for (int i = 0; i < CHANNELS; i++) begin
              if (wr_chan == CW'(i)) begin
                working_d[i] = wr_data;
              end
            end
          end else begin
            err_d = 1'b1;
          end
        end
        // An empty mask would copy nothing, so it does not start a sequence.
        if (commit && (|commit_mask)) begin
          state_d = COMMIT;
          mask_d  = commit_mask;
          idx_d   = '0;
        end
      end

      COMMIT: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if ((idx_q == CW'(i)) && mask_q[i]) begin
            shadow_d[i] = working_q[i];
          end
        end
        if ({1'b0, idx_q} == LAST_CH) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read path: sampled from the current (pre-edge) storage, so a read of a
  // channel being written or copied this cycle returns the old value.
  always_comb begin
    rd_sel      = '0;
    rd_in_range = ({1'b0, rd_chan} < NUM_CH);
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_chan == CW'(i)) begin
        rd_sel = rd_shadow ? shadow_q[i] : working_q[i];
      end
    end
    // Out-of-range reads return a plain zero, never the transformed value.
    if (!rd_in_range) begin
      rd_data_d = '0;
    end else if (INVERT != 0) begin
      rd_data_d = ~rd_sel;
    end else begin
      rd_data_d = rd_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      mask_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        working_q[i] <= '0;
        shadow_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      for (int i = 0; i < CHANNELS; i++) begin
        working_q[i] <= working_d[i];
        shadow_q[i]  <= shadow_d[i];
      end
    end
  end

endmodule

// File: tb/tb_shadow_reg_bank.sv
// Purpose: directed self-checking bench for shadow_reg_bank.
// Three instances: 0 = 4 ch pass-through, 1 = 4 ch inverting,
// 2 = 3 ch inverting (out-of-range channel exists).
module tb_shadow_reg_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst         [3];
  logic       wr_valid    [3];
  logic       wr_ready    [3];
  logic [1:0] wr_chan     [3];
  logic [7:0] wr_data     [3];
  logic       commit      [3];
  logic [3:0] commit_mask [3];
  logic       busy        [3];
  logic       done        [3];
  logic [1:0] rd_chan     [3];
  logic       rd_shadow   [3];
  logic [7:0] rd_data     [3];
  logic       err         [3];

  int checks = 0;
  int errors = 0;

  shadow_reg_bank #(.WIDTH(8), .CHANNELS(4), .INVERT(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]),
    .wr_chan(wr_chan[0]), .wr_data(wr_data[0]), .commit(commit[0]),
    .commit_mask(commit_mask[0]), .busy(busy[0]), .done(done[0]),
    .rd_chan(rd_chan[0]), .rd_shadow(rd_shadow[0]), .rd_data(rd_data[0]),
    .err(err[0])
  );

  shadow_reg_bank #(.WIDTH(8), .CHANNELS(4), .INVERT(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]),
    .wr_chan(wr_chan[1]), .wr_data(wr_data[1]), .commit(commit[1]),
    .commit_mask(commit_mask[1]), .busy(busy[1]), .done(done[1]),
    .rd_chan(rd_chan[1]), .rd_shadow(rd_shadow[1]), .rd_data(rd_data[1]),
    .err(err[1])
  );

  shadow_reg_bank #(.WIDTH(8), .CHANNELS(3), .INVERT(1)) u_dut2 (
    .clk(clk), .rst(rst[2]), .wr_valid(wr_valid[2]), .wr_ready(wr_ready[2]),
    .wr_chan(wr_chan[2]), .wr_data(wr_data[2]), .commit(commit[2]),
    .commit_mask(commit_mask[2][2:0]), .busy(busy[2]), .done(done[2]),
    .rd_chan(rd_chan[2]), .rd_shadow(rd_shadow[2]), .rd_data(rd_data[2]),
    .err(err[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic wr(input int d, input logic [1:0] ch, input logic [7:0] v);
    wr_valid[d] = 1'b1;
    wr_chan[d]  = ch;
    wr_data[d]  = v;
    @(negedge clk);
    wr_valid[d] = 1'b0;
  endtask

  task automatic rd(input int d, input logic [1:0] ch, input logic sh, output logic [7:0] v);
    rd_chan[d]   = ch;
    rd_shadow[d] = sh;
    @(negedge clk);
    v = rd_data[d];
  endtask

  // Issues a commit and watches 8 cycles; n = 0 is the first cycle after
  // the accepting edge. 'extra' re-asserts commit mid-sequence.
  task automatic commit_seq(input int d, input logic [3:0] m, input bit extra,
                            output int bcnt, output int dcnt, output int dat);
    bcnt = 0;
    dcnt = 0;
    dat  = -1;
    commit[d]      = 1'b1;
    commit_mask[d] = m;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (busy[d]) bcnt++;
      if (done[d]) begin
        dcnt++;
        dat = n;
      end
      if (n == 0) begin
        wr_valid[d]    = 1'b0;
        commit[d]      = extra;
        commit_mask[d] = 4'hF;
      end
      if (n == 1) commit[d] = 1'b0;
    end
  endtask

  logic [7:0] v;
  int bc, dc, da;

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; wr_valid[d] = 1'b0; wr_chan[d] = '0; wr_data[d] = '0;
      commit[d] = 1'b0; commit_mask[d] = '0; rd_chan[d] = '0; rd_shadow[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    // Reset state
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_rdy%0d", d),  32'(wr_ready[d]), 32'd1);
      check($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
      check($sformatf("rst_done%0d", d), 32'(done[d]), 32'd0);
      check($sformatf("rst_err%0d", d),  32'(err[d]), 32'd0);
      check($sformatf("rst_rd%0d", d),   32'(rd_data[d]), 32'd0);
    end
    for (int c = 0; c < 4; c++) begin
      for (int s = 0; s < 2; s++) begin
        rd(0, 2'(c), 1'(s), v);
        check($sformatf("rst_ch%0d_sh%0d", c, s), 32'(v), 32'h00);
      end
    end

    // Write then commit
    wr(0, 2'd2, 8'hA5);
    commit_seq(0, 4'b0100, 1'b0, bc, dc, da);
    check("wc_busy_cycles", 32'(bc), 32'd4);
    check("wc_done_count", 32'(dc), 32'd1);
    check("wc_done_at", 32'(da), 32'd4);
    rd(0, 2'd2, 1'b1, v); check("wc_sh2", 32'(v), 32'hA5);
    rd(0, 2'd1, 1'b1, v); check("wc_sh1", 32'(v), 32'h00);
    rd(0, 2'd2, 1'b0, v); check("wc_wk2", 32'(v), 32'hA5);

    // Write and commit in the same cycle: commit copies the new value
    wr_valid[0] = 1'b1; wr_chan[0] = 2'd0; wr_data[0] = 8'h5A;
    commit_seq(0, 4'b0001, 1'b0, bc, dc, da);
    check("same_done", 32'(dc), 32'd1);
    rd(0, 2'd0, 1'b1, v); check("same_sh0", 32'(v), 32'h5A);
    rd(0, 2'd2, 1'b1, v); check("same_sh2_kept", 32'(v), 32'hA5);

    // Zero mask is ignored
    commit_seq(0, 4'b0000, 1'b0, bc, dc, da);
    check("zmask_busy", 32'(bc), 32'd0);
    check("zmask_done", 32'(dc), 32'd0);

    // Handshake: write held through a commit, mid-sequence commit ignored
    wr(0, 2'd1, 8'h33);
    commit[0] = 1'b1; commit_mask[0] = 4'b0010;
    rd_chan[0] = 2'd1; rd_shadow[0] = 1'b0;
    dc = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done[0]) dc++;
      if (n <= 3) check($sformatf("hs_rdy_n%0d", n), 32'(wr_ready[0]), 32'd0);
      if (n == 4) check("hs_rdy_done", 32'(wr_ready[0]), 32'd1);
      if (n == 4) check("hs_done_at4", 32'(done[0]), 32'd1);
      if (n >= 1 && n <= 5) check($sformatf("hs_wk_old_n%0d", n), 32'(rd_data[0]), 32'h33);
      if (n == 6) check("hs_wk_new", 32'(rd_data[0]), 32'h77);
      if (n == 0) begin
        wr_valid[0] = 1'b1; wr_chan[0] = 2'd1; wr_data[0] = 8'h77;
      end
      if (n == 1) commit[0] = 1'b0;
      if (n == 5) wr_valid[0] = 1'b0;
    end
    check("hs_done_count", 32'(dc), 32'd1);
    rd(0, 2'd1, 1'b1, v); check("hs_sh1", 32'(v), 32'h33);

    // Mid-sequence commit via helper: still one done pulse
    commit_seq(0, 4'b0010, 1'b1, bc, dc, da);
    check("mid_commit_done", 32'(dc), 32'd1);
    check("mid_commit_busy", 32'(bc), 32'd4);

    // Reset mid-commit
    wr(0, 2'd3, 8'h44);
    commit_seq(0, 4'b1111, 1'b0, bc, dc, da);
    rd(0, 2'd3, 1'b1, v); check("pre_rst_sh3", 32'(v), 32'h44);
    commit[0] = 1'b1; commit_mask[0] = 4'b1111;
    @(negedge clk);
    check("mr_busy_n0", 32'(busy[0]), 32'd1);
    commit[0] = 1'b0;
    @(negedge clk);
    check("mr_busy_n1", 32'(busy[0]), 32'd1);
    rst[0] = 1'b1;
    @(negedge clk);
    check("mr_busy_after", 32'(busy[0]), 32'd0);
    check("mr_rdy_after", 32'(wr_ready[0]), 32'd1);
    rst[0] = 1'b0;
    dc = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done[0]) dc++;
    end
    check("mr_no_done", 32'(dc), 32'd0);
    for (int c = 0; c < 4; c++) begin
      rd(0, 2'(c), 1'b1, v);
      check($sformatf("mr_sh%0d", c), 32'(v), 32'h00);
    end
    rd(0, 2'd3, 1'b0, v); check("mr_wk3", 32'(v), 32'h00);

    // Masking and invert
    wr(1, 2'd0, 8'h0F);
    wr(1, 2'd3, 8'h3C);
    commit_seq(1, 4'b0001, 1'b0, bc, dc, da);
    check("inv_busy", 32'(bc), 32'd4);
    rd(1, 2'd0, 1'b1, v); check("inv_sh0", 32'(v), 32'hF0);
    rd(1, 2'd3, 1'b1, v); check("inv_sh3", 32'(v), 32'hFF);
    rd(1, 2'd3, 1'b0, v); check("inv_wk3", 32'(v), 32'hC3);
    rd(1, 2'd0, 1'b0, v); check("inv_wk0", 32'(v), 32'hF0);

    // Out-of-range on a 3-channel inverting bank
    wr(2, 2'd1, 8'h12);
    check("oor_err_before", 32'(err[2]), 32'd0);
    wr(2, 2'd3, 8'h99);
    check("oor_err_set", 32'(err[2]), 32'd1);
    rd(2, 2'd3, 1'b0, v); check("oor_rd_wk", 32'(v), 32'h00);
    rd(2, 2'd3, 1'b1, v); check("oor_rd_sh", 32'(v), 32'h00);
    rd(2, 2'd1, 1'b0, v); check("oor_wk1", 32'(v), 32'hED);
    rd(2, 2'd0, 1'b0, v); check("oor_wk0", 32'(v), 32'hFF);
    rd(2, 2'd2, 1'b0, v); check("oor_wk2", 32'(v), 32'hFF);
    commit_seq(2, 4'b0111, 1'b0, bc, dc, da);
    check("c3_busy", 32'(bc), 32'd3);
    check("c3_done_at", 32'(da), 32'd3);
    rd(2, 2'd1, 1'b1, v); check("c3_sh1", 32'(v), 32'hED);
    check("oor_err_sticky", 32'(err[2]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shadow_reg_bank.md
# shadow_reg_bank

Parametrised multi-channel register bank with a working copy and a shadow copy per channel, plus an optional inverting read path. Writes land in the working copy. A commit sequence, run by a small state machine, transfers a masked set of channels into the shadow copy one channel per cycle. The block sits between a configuration master and consumers that must only see atomically committed values. It generalises the single-integer, single-invert-function storage pattern to N channels, arbitrary width, a selectable read transform and a staged update.

## Interface
Parameters:
- WIDTH, 8: bits per channel.
- CHANNELS, 4: number of channels; must be ≥ 2.
- INVERT, 0: read transform. 0 = pass-through; 1 = bitwise inversion (~v) of in-range reads.
- CW (derived, not overridable): $clog2(CHANNELS).

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- wr_valid  input  1  write request.
- wr_ready  output  1  bank can accept a write.
- wr_chan  input  CW  write channel index.
- wr_data  input  WIDTH  write data.
- commit  input  1  start commit sequence.
- commit_mask  input  CHANNELS  bit i set = copy channel i.
- busy  output  1  commit sequence in progress.
- done  output  1  one-cycle pulse at end of commit.
- rd_chan  input  CW  read channel index.
- rd_shadow  input  1  1 = read shadow copy; 0 = read working copy.
- rd_data  output  WIDTH  registered read result.
- err  output  1  sticky flag: an out-of-range write was attempted.

## Operation
- Storage: working[CHANNELS] and shadow[CHANNELS], each WIDTH bits.
- State machine has two states, IDLE and COMMIT.
- IDLE:
  - wr_ready = 1 and busy = 0.
  - Write fires when wr_valid && wr_ready. It then sets working[wr_chan] <= wr_data.
  - If wr_chan ≥ CHANNELS, the write is dropped and err <= 1.
  - commit with commit_mask != 0: latch the mask into mask_q, clear idx to 0, and go to COMMIT.
  - commit with commit_mask == 0: ignored. No state change and no done pulse.
  - Write and commit in the same cycle: the write is applied. Copies happen in later cycles, so the commit sees the new value.
- COMMIT:
  - wr_ready = 0 and busy = 1.
  - Writes are not accepted.
  - commit is ignored.
  - Each cycle: if mask_q[idx], then shadow[idx] <= working[idx]. Then idx increments.
  - When idx == CHANNELS-1 is processed, go to IDLE and set done = 1 for the next cycle only.
- Read path:
  - rd_data <= T(rd_shadow ? shadow[rd_chan] : working[rd_chan]) every cycle, in any state.
  - T is ~v when INVERT = 1, and v otherwise.
  - If rd_chan ≥ CHANNELS, rd_data <= 0. The transform is not applied to this 0.
  - A read of a channel in the same cycle it is written or copied returns the old value.
- err clears only on reset.

## Timing
- Reset values:
  - All working and shadow entries are 0.
  - rd_data = 0, err = 0, done = 0, busy = 0.
  - wr_ready = 1 from the first cycle after rst deasserts.
  - State = IDLE, idx = 0, mask_q = 0.
- Read latency: 1 cycle from rd_chan/rd_shadow to rd_data.
- Write latency:
  - Data written at edge k is visible in working at edge k.
  - It appears on rd_data at edge k+1 when read in cycle k+1.
- Commit latency:
  - commit sampled at edge k puts the FSM in COMMIT from edge k.
  - Copies occur at edges k+1 … k+CHANNELS.
  - FSM returns to IDLE at edge k+CHANNELS.
  - done is high in cycle k+CHANNELS (between edges k+CHANNELS and k+CHANNELS+1).
  - busy is high for exactly CHANNELS cycles.
  - wr_ready is low for the same cycles.
- Back-to-back commit: a new commit can be accepted in the done cycle.
- rst asserted mid-commit: at the next edge all storage clears, the FSM goes to IDLE and done stays 0.
- Arithmetic:
  - idx is CW bits wide and never wraps past CHANNELS-1.
  - When CHANNELS is not a power of two, comparisons against CHANNELS use full CW+1-bit width.

## Test plan
- Reset behaviour (WIDTH=8, CHANNELS=4, INVERT=0): hold rst for 2 cycles, then read every channel with both rd_shadow values → rd_data = 0x00, wr_ready = 1, err = 0.
- Write then commit:
  - Write 0xA5 to channel 2, then commit with mask 4'b0100.
  - busy must be high for 4 cycles and done must pulse once, 4 cycles after commit.
  - Shadow read of channel 2 → 0xA5.
  - Shadow read of channel 1 → 0x00.
- Masking and invert (INVERT=1):
  - Write 0x0F to channel 0 and 0x3C to channel 3, then commit with mask 4'b0001.
  - Shadow read of channel 0 → 0xF0.
  - Shadow read of channel 3 → 0xFF.
  - Working read of channel 3 → 0xC3.
- Handshake:
  - Hold wr_valid during a commit → wr_ready = 0 and working is unchanged until the done cycle.
  - The write is then accepted.
  - A commit issued mid-sequence is ignored: a single done pulse.
- Out-of-range (CHANNELS=3):
  - Write to channel 3 → err = 1 and no storage change.
  - Read of channel 3 → 0x00 even with INVERT=1.
- Reset mid-commit (CHANNELS=4): assert rst in the 2nd busy cycle → no done, and all shadow reads = 0 afterwards.
